// File: rtl/servo_pwm_pkg.sv
// Shared types and helpers for the multi-channel servo PWM generator.
// Angle arithmetic is done in 32-bit signed so clamping and abs never wrap.
package servo_pwm_pkg;

   localparam int PERIOD  = 25_000_000 / 50;
   localparam int INT_MIN = 32'sh8000_0000;
   localparam int INT_MAX = 32'sh7fff_ffff;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MAP  = 1'b1
   } map_state_t;

   function automatic int f_period(input int freq, input int tgt);
      return freq / tgt;
   endfunction

   function automatic int f_clamp(input int a, input int lim);
      if (a > lim)  return lim;
      if (a < -lim) return -lim;
      return a;
   endfunction

   function automatic int f_abs_sat(input int a);
      if (a == INT_MIN) return INT_MAX;
      return (a < 0) ? -a : a;
   endfunction

endpackage

// File: rtl/servo_angle_map.sv
// Combinational clamp + linear map of one signed angle to a duty count.
// Shared by all channels; the capture FSM feeds it one channel per clock.
module servo_angle_map
   import servo_pwm_pkg::*;
#(
   parameter int BIT_SIZE  = 10,
   parameter int CNT_W     = 32,
   parameter int COORD_MAX = 270,
   parameter int DC_MIN    = 25_000,
   parameter int DC_MID    = 75_000,
   parameter int DC_MAX    = 125_000
) (
   input  logic signed [BIT_SIZE-1:0] i_angle,
   output logic        [CNT_W-1:0]    o_dc
);

   localparam int PW = CNT_W + BIT_SIZE;
   localparam logic [PW-1:0]    SPAN_HI = PW'(DC_MAX - DC_MID);
   localparam logic [PW-1:0]    SPAN_LO = PW'(DC_MID - DC_MIN);
   localparam logic [PW-1:0]    DIV     = PW'(COORD_MAX);
   localparam logic [CNT_W-1:0] MID     = CNT_W'(DC_MID);

   int              w_clamped;
   logic [PW-1:0]   w_mag;
   logic [PW-1:0]   w_step;

   always_comb begin
      w_clamped = f_clamp(int'(i_angle), COORD_MAX);
      w_mag     = PW'(unsigned'(f_abs_sat(w_clamped)));
      if (w_clamped < 0) begin
         w_step = (SPAN_LO * w_mag) / DIV;
         o_dc   = MID - CNT_W'(w_step);
      end else begin
         w_step = (SPAN_HI * w_mag) / DIV;
         o_dc   = MID + CNT_W'(w_step);
      end
   end

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM: angle capture with deadband, shared mapper, per-frame slew.
// state   | meaning
// IDLE    | angle_ready=1, waiting for a handshake
// MAP     | one channel per clock through deadband + mapper, ch0 first
module servo_pwm_multi
   import servo_pwm_pkg::*;
#(
   parameter int FREQ        = 25_000_000,
   parameter int TARGET_FREQ = 50,
   parameter int NUM_CH      = 3,
   parameter int BIT_SIZE    = 10,
   parameter int COORD_MAX   = 270,
   parameter int DC_MIN      = 25_000,
   parameter int DC_MID      = 75_000,
   parameter int DC_MAX      = 125_000,
   parameter int THRESHOLD   = 10,
   parameter int SLEW_STEP   = 5_000,
   parameter int CNT_W       = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [NUM_CH*BIT_SIZE-1:0] angle_in,
   input  logic                       angle_valid,
   output logic                       angle_ready,
   output logic [NUM_CH-1:0]          pwm_out,
   output logic                       frame_tick,
   output logic [NUM_CH-1:0]          settled
);

   localparam int PERIOD_CNT = f_period(FREQ, TARGET_FREQ);
   localparam int IW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CNT - 1);
   localparam logic [CNT_W-1:0] MID_C    = CNT_W'(DC_MID);
   localparam logic [CNT_W-1:0] SLEW_C   = CNT_W'(SLEW_STEP);

   if (!(DC_MIN <= DC_MID && DC_MID <= DC_MAX && DC_MAX < PERIOD_CNT && NUM_CH >= 1))
   begin : g_bad_cfg
      $error("servo_pwm_multi: invalid duty range or channel count");
   end

   map_state_t                  r_state, w_state_nxt;
   logic [IW-1:0]               r_idx;
   logic                        r_ready;
   logic signed [BIT_SIZE-1:0]  r_shadow [NUM_CH];
   logic signed [BIT_SIZE-1:0]  r_last   [NUM_CH];
   logic [CNT_W-1:0]            r_target [NUM_CH];
   logic [CNT_W-1:0]            r_active [NUM_CH];
   logic [CNT_W-1:0]            r_cnt;
   logic [NUM_CH-1:0]           r_pwm, r_settled;
   logic                        w_hs, w_tick, w_last_ch, w_accept;
   logic signed [BIT_SIZE-1:0]  w_ang;
   logic [CNT_W-1:0]            w_map_dc;

   assign w_tick      = en && (r_cnt == LAST_CNT);
   assign w_hs        = angle_valid && r_ready && (r_state == ST_IDLE);
   assign w_ang       = r_shadow[r_idx];
   assign w_last_ch   = (r_idx == IW'(NUM_CH - 1));
   assign w_accept    = f_abs_sat(int'(w_ang) - int'(r_last[r_idx])) >= THRESHOLD;

   assign angle_ready = r_ready;
   assign pwm_out     = r_pwm;
   assign frame_tick  = w_tick;
   assign settled     = r_settled;

   servo_angle_map #(
      .BIT_SIZE  (BIT_SIZE),
      .CNT_W     (CNT_W),
      .COORD_MAX (COORD_MAX),
      .DC_MIN    (DC_MIN),
      .DC_MID    (DC_MID),
      .DC_MAX    (DC_MAX)
   ) u_map (
      .i_angle (w_ang),
      .o_dc    (w_map_dc)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_hs)      w_state_nxt = ST_MAP;
         ST_MAP:  if (w_last_ch) w_state_nxt = ST_IDLE;
         default:                w_state_nxt = ST_IDLE;
      endcase
   end

   // Ready stays low one extra cycle after MAP so the ready-low window is NUM_CH+1 clocks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_ready <= 1'b1;
         for (int i = 0; i < NUM_CH; i++) r_shadow[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= (r_state == ST_IDLE) && !w_hs;
         if (w_hs) begin
            r_idx <= '0;
            for (int i = 0; i < NUM_CH; i++)
               r_shadow[i] <= angle_in[i*BIT_SIZE +: BIT_SIZE];
         end else if (r_state == ST_MAP) begin
            r_idx <= w_last_ch ? '0 : r_idx + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
         r_pwm <= '0;
      end else begin
         r_cnt <= (!en || w_tick) ? '0 : r_cnt + CNT_W'(1);
         for (int i = 0; i < NUM_CH; i++)
            r_pwm[i] <= en && (r_cnt < r_active[i]);
      end
   end

   // Slew reads the pre-edge target, so a target written on the tick edge waits a frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_settled <= '1;
         for (int i = 0; i < NUM_CH; i++) begin
            r_last[i]   <= '0;
            r_target[i] <= MID_C;
            r_active[i] <= MID_C;
         end
      end else begin
         if (r_state == ST_MAP && w_accept) begin
            r_last[r_idx]   <= w_ang;
            r_target[r_idx] <= w_map_dc;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            r_settled[i] <= (r_active[i] == r_target[i]);
            if (w_tick) begin
               if (r_target[i] > r_active[i]) begin
                  if (SLEW_STEP == 0 || (r_target[i] - r_active[i]) <= SLEW_C)
                     r_active[i] <= r_target[i];
                  else
                     r_active[i] <= r_active[i] + SLEW_C;
               end else begin
                  if (SLEW_STEP == 0 || (r_active[i] - r_target[i]) <= SLEW_C)
                     r_active[i] <= r_target[i];
                  else
                     r_active[i] <= r_active[i] - SLEW_C;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench: PERIOD=100, duty 10/30/50; instance A unlimited slew, B slew 8.
module tb_servo_pwm_multi;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en  = 1'b1;
   logic [29:0] angle_in = '0;
   logic        angle_valid = 1'b0;
   logic        ready_a, ready_b, tick_a, tick_b;
   logic [2:0]  pwm_a, pwm_b, settled_a, settled_b;

   int total = 0;
   int bad   = 0;
   int hA0, hA1, hA2, hB0, tks;
   logic tk_last, sB0;

   always #5 clk = ~clk;

   servo_pwm_multi #(.FREQ(1000), .TARGET_FREQ(10), .NUM_CH(3), .BIT_SIZE(10),
      .COORD_MAX(270), .DC_MIN(10), .DC_MID(30), .DC_MAX(50), .THRESHOLD(10),
      .SLEW_STEP(0), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .en(en), .angle_in(angle_in), .angle_valid(angle_valid),
      .angle_ready(ready_a), .pwm_out(pwm_a), .frame_tick(tick_a), .settled(settled_a));

   servo_pwm_multi #(.FREQ(1000), .TARGET_FREQ(10), .NUM_CH(3), .BIT_SIZE(10),
      .COORD_MAX(270), .DC_MIN(10), .DC_MID(30), .DC_MAX(50), .THRESHOLD(10),
      .SLEW_STEP(8), .CNT_W(32)) dut_b (
      .clk(clk), .rst(rst), .en(en), .angle_in(angle_in), .angle_valid(angle_valid),
      .angle_ready(ready_b), .pwm_out(pwm_b), .frame_tick(tick_b), .settled(settled_b));

   typedef struct {
      logic [29:0] ang;
      int          e0, e1, e2;
   } vec_t;

   vec_t vt[6];

   function automatic logic [29:0] pack3(input int a0, input int a1, input int a2);
      logic [9:0] b0, b1, b2;
      b0 = a0[9:0];
      b1 = a1[9:0];
      b2 = a2[9:0];
      return {b2, b1, b0};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ready_a && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("ready_timeout", 0, 1);
   endtask

   task automatic send(input logic [29:0] ang);
      int n = 0;
      @(negedge clk);
      wait_ready();
      angle_in    = ang;
      angle_valid = 1'b1;
      @(negedge clk);
      angle_valid = 1'b0;
      while (!ready_a && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("ready_low_clks", n, 4);
   endtask

   task automatic wait_tick();
      int n = 0;
      while (!tick_a && n < 250) begin
         @(negedge clk);
         n++;
      end
      if (n >= 250) chk("tick_timeout", 0, 1);
   endtask

   task automatic count_frame();
      hA0 = 0; hA1 = 0; hA2 = 0; hB0 = 0; tks = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         hA0 += int'(pwm_a[0]);
         hA1 += int'(pwm_a[1]);
         hA2 += int'(pwm_a[2]);
         hB0 += int'(pwm_b[0]);
         if (tick_a) tks++;
      end
      tk_last = tick_a;
      sB0     = settled_b[0];
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int pw_hi, ticks_off;

      vt[0] = '{pack3( 270, -270,  135), 50, 10, 40};
      vt[1] = '{pack3( 265, -270,  135), 50, 10, 40};
      vt[2] = '{pack3(-512, -265,  100), 10, 10, 37};
      vt[3] = '{pack3(   0,    9,  109), 30, 30, 37};
      vt[4] = '{pack3(  -1,   19, -100), 30, 31, 23};
      vt[5] = '{pack3( 511, -135,  -10), 50, 20, 30};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_pwm",     int'(pwm_a), 0);
      chk("rst_ready",   int'(ready_a), 1);
      chk("rst_tick",    int'(tick_a), 0);
      chk("rst_settled", int'(settled_a), 7);
      rst = 1'b1;

      // idle output: 30/100 on every channel, one tick per frame
      wait_tick();
      count_frame();
      chk("idle_hi0", hA0, 30);
      chk("idle_hi1", hA1, 30);
      chk("idle_hi2", hA2, 30);
      chk("idle_ticks", tks, 1);
      chk("idle_tick_pos", int'(tk_last), 1);
      chk("idle_settled", int'(settled_a), 7);

      // table: deadband, clamp and mapping
      for (int v = 0; v < 6; v++) begin
         send(vt[v].ang);
         wait_tick();
         count_frame();
         chk($sformatf("vec%0d_hi0", v), hA0, vt[v].e0);
         chk($sformatf("vec%0d_hi1", v), hA1, vt[v].e1);
         chk($sformatf("vec%0d_hi2", v), hA2, vt[v].e2);
         chk($sformatf("vec%0d_settled", v), int'(settled_a), 7);
      end

      // valid held high: one capture per ready window
      @(negedge clk);
      wait_ready();
      angle_in    = vt[5].ang;
      angle_valid = 1'b1;
      pw_hi = 0;
      for (int i = 0; i < 20; i++) begin
         if (ready_a) pw_hi++;
         @(negedge clk);
      end
      angle_valid = 1'b0;
      chk("hold_valid_captures", pw_hi, 4);

      // ch0 target written on the tick edge: old duty this frame, new next frame
      wait_ready();
      wait_tick();
      repeat (99) @(negedge clk);
      chk("pre_tick_ready", int'(ready_a), 1);
      angle_in    = pack3(0, -135, -10);
      angle_valid = 1'b1;
      @(negedge clk);
      angle_valid = 1'b0;
      chk("map_in_tick_cycle", int'(tick_a), 1);
      count_frame();
      chk("tick_wr_old_hi0", hA0, 50);
      count_frame();
      chk("tick_wr_new_hi0", hA0, 30);
      chk("tick_wr_new_hi1", hA1, 20);

      // en=0: outputs low, no ticks, capture still runs, duties frozen
      @(negedge clk);
      en = 1'b0;
      pw_hi = 0;
      ticks_off = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (pwm_a != 0) pw_hi++;
         if (tick_a) ticks_off++;
      end
      send(pack3(270, 270, 270));
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (pwm_a != 0) pw_hi++;
         if (tick_a) ticks_off++;
      end
      chk("en0_pwm_high_clks", pw_hi, 0);
      chk("en0_ticks", ticks_off, 0);
      en = 1'b1;
      count_frame();
      chk("en1_frozen_hi0", hA0, 30);
      chk("en1_frozen_hi1", hA1, 20);
      chk("en1_frozen_hi2", hA2, 30);
      wait_tick();
      count_frame();
      chk("en1_new_hi0", hA0, 50);
      chk("en1_new_hi1", hA1, 50);
      chk("en1_new_hi2", hA2, 50);

      // slew-limited ramp on instance B: 30 -> 38 -> 46 -> 50
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      send(pack3(270, 0, 0));
      wait_tick();
      count_frame();
      chk("slew_f1_hi", hB0, 38);
      chk("slew_f1_settled", int'(sB0), 0);
      chk("noslew_f1_hi", hA0, 50);
      count_frame();
      chk("slew_f2_hi", hB0, 46);
      chk("slew_f2_settled", int'(sB0), 0);
      count_frame();
      chk("slew_f3_hi", hB0, 50);
      chk("slew_f3_settled", int'(sB0), 1);

      // async reset mid-MAP and mid-pulse
      wait_tick();
      repeat (5) @(negedge clk);
      angle_in    = pack3(-270, -270, -270);
      angle_valid = 1'b1;
      @(negedge clk);
      angle_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_ready", int'(ready_a), 0);
      chk("pre_rst_pwm", int'(pwm_a), 7);
      rst = 1'b0;
      #1;
      chk("async_rst_pwm", int'(pwm_a), 0);
      chk("async_rst_pwm_b", int'(pwm_b), 0);
      chk("async_rst_ready", int'(ready_a), 1);
      chk("async_rst_settled", int'(settled_a), 7);
      @(negedge clk);
      rst = 1'b1;
      wait_tick();
      count_frame();
      chk("post_rst_hi0", hA0, 30);
      chk("post_rst_hi1", hA1, 30);
      chk("post_rst_hi2", hA2, 30);
      chk("post_rst_hiB", hB0, 30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
